// File: rtl/epd_frame_arbiter.sv
// Round-robin frame arbiter feeding the byte-wide epd input; polices length and underrun.
// Latency: 1 cycle from accepted source byte to o_out_data/o_out_control.
// Backpressure: only the granted source sees o_src_ready (XFER/DRAIN); others hold valid until granted in IDLE.
module epd_frame_arbiter #(
    parameter int NUM_SRC   = 2,
    parameter int IFG_MIN   = 2,
    parameter int MAX_BYTES = 72
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic [NUM_SRC-1:0]   i_src_valid,
    input  logic [8*NUM_SRC-1:0] i_src_data,
    input  logic [NUM_SRC-1:0]   i_src_last,
    output logic [NUM_SRC-1:0]   o_src_ready,
    output logic [7:0]           o_out_data,
    output logic                 o_out_control,
    output logic [1:0]           o_grant_id,
    output logic                 o_busy,
    output logic                 o_oversize,
    output logic                 o_underrun,
    output logic [7:0]           o_frame_count
);

    localparam int CW = $clog2(MAX_BYTES + 1);
    localparam int IW = (IFG_MIN > 1) ? $clog2(IFG_MIN) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_XFER  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_IFG   = 2'd3;

    localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_BYTES);
    localparam logic [IW-1:0] IFG_LAST = IW'(IFG_MIN - 1);

    logic [1:0]    r_state;
    logic [1:0]    r_grant;
    logic [CW-1:0] r_cnt;
    logic [IW-1:0] r_ifg;
    logic [7:0]    r_out_data;
    logic          r_out_ctl;
    logic          r_oversize;
    logic          r_underrun;
    logic [7:0]    r_frame_count;

    logic          w_g_valid;
    logic          w_g_last;
    logic [7:0]    w_g_data;
    logic          w_any;
    logic          w_hi_found;
    logic [1:0]    w_hi;
    logic [1:0]    w_lo;
    logic [1:0]    w_next;
    logic [CW-1:0] w_cnt_inc;

    // Mux the granted source's valid/last/data onto a single lane.
    always_comb begin
        w_g_valid = 1'b0;
        w_g_last  = 1'b0;
        w_g_data  = 8'h00;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_grant == 2'(i)) begin
                w_g_valid = i_src_valid[i];
                w_g_last  = i_src_last[i];
                w_g_data  = i_src_data[8*i +: 8];
            end
        end
    end

    // Round-robin pick: lowest requester above the last grant, else lowest requester overall.
    always_comb begin
        w_any      = 1'b0;
        w_hi_found = 1'b0;
        w_hi       = 2'd0;
        w_lo       = 2'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (i_src_valid[i]) begin
                w_any = 1'b1;
                w_lo  = 2'(i);
                if (2'(i) > r_grant) begin
                    w_hi_found = 1'b1;
                    w_hi       = 2'(i);
                end
            end
        end
        w_next = w_hi_found ? w_hi : w_lo;
    end

    // Ready goes only to the granted source while its frame is being taken or discarded.
    always_comb begin
        o_src_ready = '0;
        if (r_state == ST_XFER || r_state == ST_DRAIN) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                o_src_ready[i] = (r_grant == 2'(i));
            end
        end
    end

    assign w_cnt_inc = r_cnt + CW'(1);

    // Frame FSM, output register and status pulses.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state       <= ST_IDLE;
            r_grant       <= 2'(NUM_SRC - 1);
            r_cnt         <= '0;
            r_ifg         <= '0;
            r_out_data    <= 8'h00;
            r_out_ctl     <= 1'b0;
            r_oversize    <= 1'b0;
            r_underrun    <= 1'b0;
            r_frame_count <= 8'h00;
        end else begin
            r_out_data <= 8'h00;
            r_out_ctl  <= 1'b0;
            r_oversize <= 1'b0;
            r_underrun <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_next;
                        r_cnt   <= '0;
                        r_state <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (!w_g_valid) begin
                        // A hole mid-frame would let epd merge fragments; break the frame here.
                        r_underrun <= 1'b1;
                        r_state    <= ST_DRAIN;
                    end else begin
                        r_out_data <= w_g_data;
                        r_out_ctl  <= 1'b1;
                        r_cnt      <= w_cnt_inc;
                        if (w_g_last) begin
                            // Last byte wins over the length limit on the same accept.
                            r_frame_count <= r_frame_count + 8'd1;
                            r_ifg         <= '0;
                            r_state       <= ST_IFG;
                        end else if (w_cnt_inc == MAX_CNT) begin
                            r_oversize <= 1'b1;
                            r_state    <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_g_valid && w_g_last) begin
                        r_ifg   <= '0;
                        r_state <= ST_IFG;
                    end
                end
                ST_IFG: begin
                    if (r_ifg == IFG_LAST) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_ifg <= r_ifg + IW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_out_data    = r_out_data;
    assign o_out_control = r_out_ctl;
    assign o_grant_id    = r_grant;
    assign o_busy        = (r_state != ST_IDLE);
    assign o_oversize    = r_oversize;
    assign o_underrun    = r_underrun;
    assign o_frame_count = r_frame_count;

endmodule

// File: tb/tb_epd_frame_arbiter.sv
// Directed bench for epd_frame_arbiter: frame vectors table plus contention and reset sequences.
// Latency: checks the 1-cycle forward and IFG spacing of 3 idle cycles.
// Backpressure: drivers only advance a byte when o_src_ready was high at the preceding edge.
module tb_epd_frame_arbiter;

    localparam int NUM_SRC = 2;

    logic         i_clock;
    logic         i_reset;
    logic [1:0]   i_src_valid;
    logic [15:0]  i_src_data;
    logic [1:0]   i_src_last;
    logic [1:0]   o_src_ready;
    logic [7:0]   o_out_data;
    logic         o_out_control;
    logic [1:0]   o_grant_id;
    logic         o_busy;
    logic         o_oversize;
    logic         o_underrun;
    logic [7:0]   o_frame_count;

    epd_frame_arbiter #(.NUM_SRC(NUM_SRC), .IFG_MIN(2), .MAX_BYTES(72)) dut (
        .i_clock(i_clock), .i_reset(i_reset),
        .i_src_valid(i_src_valid), .i_src_data(i_src_data), .i_src_last(i_src_last),
        .o_src_ready(o_src_ready), .o_out_data(o_out_data), .o_out_control(o_out_control),
        .o_grant_id(o_grant_id), .o_busy(o_busy), .o_oversize(o_oversize),
        .o_underrun(o_underrun), .o_frame_count(o_frame_count)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] got_q[$];
    int         gid_q[$];
    int         gap_q[$];
    int         ovf_cnt = 0;
    int         und_cnt = 0;
    int         bad_idle = 0;
    int         idle_run = 0;
    bit         seen = 0;
    bit         prev_ctl = 0;

    typedef struct {
        int src;
        int len;
        int drop_at;
        int exp_fwd;
        int exp_ovf;
        int exp_und;
        int exp_inc;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference epd frame: preamble, SFD, DST 01..06, SRC FF..FA, type 0800, 49x55, FF.
    function automatic logic [7:0] pkt_byte(input int n, input int s);
        logic [7:0] b;
        if (n < 7)       b = 8'h55;
        else if (n == 7) b = 8'hD5;
        else if (n < 14) b = 8'(n - 7);
        else if (n < 20) b = 8'(255 - (n - 14));
        else if (n == 20) b = 8'h08;
        else if (n == 21) b = 8'h00;
        else if (n < 71) b = 8'h55;
        else if (n == 71) b = 8'hFF;
        else             b = 8'hEE;
        return b ^ 8'(s * 17);
    endfunction

    // Output monitor, sampled on the falling edge.
    always @(negedge i_clock) begin
        if (!i_reset) begin
            prev_ctl = 0;
            seen     = 0;
            idle_run = 0;
        end else begin
            if (o_out_control) begin
                got_q.push_back(o_out_data);
                if (!prev_ctl) begin
                    gid_q.push_back(int'(o_grant_id));
                    if (seen) gap_q.push_back(idle_run);
                    seen = 1;
                end
                idle_run = 0;
            end else begin
                idle_run++;
                if (o_out_data != 8'h00) bad_idle++;
            end
            if (o_oversize) ovf_cnt++;
            if (o_underrun) und_cnt++;
            prev_ctl = o_out_control;
        end
    end

    // Drive one frame from source s; drop valid for one cycle after drop_at accepts;
    // return early with valid still high after stop_at accepts.
    task automatic send_frame(input int s, input int len, input int drop_at, input int stop_at);
        int   n = 0;
        int   cyc = 0;
        bit   dropped = 0;
        logic acc;
        while (n < len && n != stop_at && cyc < 400) begin
            if (n == drop_at && !dropped) begin
                i_src_valid[s] = 1'b0;
                i_src_last[s]  = 1'b0;
                @(posedge i_clock); #1;
                cyc++;
                dropped = 1;
            end else begin
                i_src_valid[s]       = 1'b1;
                i_src_data[8*s +: 8] = pkt_byte(n, s);
                i_src_last[s]        = (n == len - 1);
                @(negedge i_clock);
                acc = o_src_ready[s];
                @(posedge i_clock); #1;
                cyc++;
                if (acc) n++;
            end
        end
        if (n != stop_at) begin
            i_src_valid[s] = 1'b0;
            i_src_last[s]  = 1'b0;
        end
        if (cyc >= 400) begin
            n_tests++;
            n_fail++;
            $display("FAIL drv_timeout src%0d: accepted %0d of %0d bytes", s, n, len);
        end
    endtask

    task automatic wait_idle(input string name);
        int c = 0;
        @(negedge i_clock);
        while (o_busy && c < 200) begin
            @(negedge i_clock);
            c++;
        end
        check(name, o_busy, 0);
        @(posedge i_clock); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_fc;
        int mism;

        vecs[0] = '{src: 0, len: 72, drop_at: -1, exp_fwd: 72, exp_ovf: 0, exp_und: 0, exp_inc: 1};
        vecs[1] = '{src: 1, len: 10, drop_at: -1, exp_fwd: 10, exp_ovf: 0, exp_und: 0, exp_inc: 1};
        vecs[2] = '{src: 0, len: 80, drop_at: -1, exp_fwd: 72, exp_ovf: 1, exp_und: 0, exp_inc: 0};
        vecs[3] = '{src: 1, len: 12, drop_at: -1, exp_fwd: 12, exp_ovf: 0, exp_und: 0, exp_inc: 1};
        vecs[4] = '{src: 0, len: 40, drop_at: 20, exp_fwd: 20, exp_ovf: 0, exp_und: 1, exp_inc: 0};
        vecs[5] = '{src: 0, len: 73, drop_at: -1, exp_fwd: 72, exp_ovf: 1, exp_und: 0, exp_inc: 0};
        vecs[6] = '{src: 1, len: 1,  drop_at: -1, exp_fwd: 1,  exp_ovf: 0, exp_und: 0, exp_inc: 1};
        vecs[7] = '{src: 0, len: 71, drop_at: -1, exp_fwd: 71, exp_ovf: 0, exp_und: 0, exp_inc: 1};

        i_reset     = 1'b0;
        i_src_valid = '0;
        i_src_data  = '0;
        i_src_last  = '0;
        repeat (3) @(posedge i_clock);
        @(negedge i_clock);
        check("rst_ctl",   o_out_control, 0);
        check("rst_data",  o_out_data, 0);
        check("rst_ready", o_src_ready, 0);
        check("rst_gid",   o_grant_id, 1);
        check("rst_busy",  o_busy, 0);
        check("rst_fc",    o_frame_count, 0);
        check("rst_ovf",   o_oversize, 0);
        check("rst_und",   o_underrun, 0);
        @(posedge i_clock); #1;
        i_reset = 1'b1;

        // Single-byte frame: ready timing and 1-cycle forward latency.
        i_src_valid[0]   = 1'b1;
        i_src_data[7:0]  = 8'h5A;
        i_src_last[0]    = 1'b1;
        @(negedge i_clock);
        check("d_ready_idle", o_src_ready, 0);
        check("d_busy_idle",  o_busy, 0);
        @(posedge i_clock); #1;
        @(negedge i_clock);
        check("d_ready_xfer", o_src_ready, 2'b01);
        check("d_ctl_xfer",   o_out_control, 0);
        check("d_gid",        o_grant_id, 0);
        @(posedge i_clock); #1;
        i_src_valid[0] = 1'b0;
        i_src_last[0]  = 1'b0;
        @(negedge i_clock);
        check("d_ctl_fwd",  o_out_control, 1);
        check("d_data_fwd", o_out_data, 8'h5A);
        check("d_ready_ifg", o_src_ready, 0);
        @(negedge i_clock);
        check("d_ctl_gap",  o_out_control, 0);
        check("d_data_gap", o_out_data, 0);
        check("d_fc",       o_frame_count, 1);
        wait_idle("d_idle");
        exp_fc = 1;

        // Frame vector table.
        for (int v = 0; v < 8; v++) begin
            got_q.delete();
            ovf_cnt = 0;
            und_cnt = 0;
            send_frame(vecs[v].src, vecs[v].len, vecs[v].drop_at, -1);
            wait_idle($sformatf("v%0d_idle", v));
            exp_fc += vecs[v].exp_inc;
            mism = 0;
            foreach (got_q[k]) if (got_q[k] !== pkt_byte(k, vecs[v].src)) mism++;
            check($sformatf("v%0d_fwd_len", v), got_q.size(), vecs[v].exp_fwd);
            check($sformatf("v%0d_data_mism", v), mism, 0);
            check($sformatf("v%0d_oversize", v), ovf_cnt, vecs[v].exp_ovf);
            check($sformatf("v%0d_underrun", v), und_cnt, vecs[v].exp_und);
            check($sformatf("v%0d_fc", v), o_frame_count, exp_fc);
        end

        // Three back-to-back src1 frames while src0 is idle.
        got_q.delete(); gid_q.delete(); gap_q.delete();
        seen = 0;
        for (int f = 0; f < 3; f++) send_frame(1, 16, -1, -1);
        wait_idle("a_idle");
        exp_fc += 3;
        check("a_fc", o_frame_count, exp_fc);
        check("a_bytes", got_q.size(), 48);
        check("a_nframes", gid_q.size(), 3);
        foreach (gid_q[k]) check($sformatf("a_gid%0d", k), gid_q[k], 1);
        check("a_ngaps", gap_q.size(), 2);
        foreach (gap_q[k]) check($sformatf("a_gap%0d", k), gap_q[k], 3);

        // Reset during byte 30 of a src1 frame, then both sources from release.
        send_frame(1, 60, -1, 30);
        #2;
        i_reset = 1'b0;
        #1;
        check("r_ctl",   o_out_control, 0);
        check("r_ready", o_src_ready, 0);
        check("r_fc",    o_frame_count, 0);
        check("r_busy",  o_busy, 0);
        check("r_gid",   o_grant_id, 1);
        i_src_valid = '0;
        i_src_last  = '0;
        got_q.delete(); gid_q.delete(); gap_q.delete();
        repeat (2) @(posedge i_clock);
        #1;
        i_reset = 1'b1;
        fork
            send_frame(0, 72, -1, -1);
            send_frame(1, 20, -1, -1);
        join
        wait_idle("b_idle");
        check("b_fc", o_frame_count, 2);
        check("b_nframes", gid_q.size(), 2);
        if (gid_q.size() == 2) begin
            check("b_gid_first", gid_q[0], 0);
            check("b_gid_second", gid_q[1], 1);
        end
        check("b_ngaps", gap_q.size(), 1);
        if (gap_q.size() == 1) check("b_gap", gap_q[0], 3);
        check("b_bytes", got_q.size(), 92);
        mism = 0;
        foreach (got_q[k]) begin
            if (k < 72) begin
                if (got_q[k] !== pkt_byte(k, 0)) mism++;
            end else begin
                if (got_q[k] !== pkt_byte(k - 72, 1)) mism++;
            end
        end
        check("b_data_mism", mism, 0);
        check("idle_data_zero", bad_idle, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/epd_frame_arbiter.md
Name: epd_frame_arbiter

Overview:
Shares the single byte-wide input of the Ethernet packet detector (epd) between NUM_SRC frame sources. It grants one source per frame in round-robin order and forwards its bytes onto the detector's data/control pair with 1-cycle latency. After each frame it inserts at least IFG_MIN idle cycles (control=0). It polices frame length and mid-frame underrun so the detector never sees two frames merged. Sits directly upstream of epd.

Parameters:
NUM_SRC, 2, number of requesting sources (2..4)
IFG_MIN, 2, minimum idle cycles between forwarded frames (>=1)
MAX_BYTES, 72, maximum forwarded bytes per frame including preamble/SFD (8 + 64)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
src_valid  input  NUM_SRC  per-source byte valid; asserted continuously from first to last byte of a frame
src_data  input  8*NUM_SRC  per-source byte; source i occupies bits [8i+7:8i]
src_last  input  NUM_SRC  marks the final byte of the frame (qualified by valid&ready)
src_ready  output  NUM_SRC  combinational; high only for the granted source in XFER or DRAIN
out_data  output  8  registered byte to epd data
out_control  output  1  registered; 1 = frame byte, 0 = idle/IFG (out_data=8'h00)
grant_id  output  2  index of the current or last granted source
busy  output  1  high in XFER, DRAIN, IFG
oversize  output  1  1-cycle pulse when MAX_BYTES is reached without src_last
underrun  output  1  1-cycle pulse when the granted source drops src_valid mid-frame
frame_count  output  8  frames completed normally (last byte forwarded); wraps 255->0

Behaviour:
- Reset (reset=0, async): state=IDLE, out_data=0, out_control=0, src_ready=0, grant_id=NUM_SRC-1 (so source 0 wins first), busy=0, oversize=0, underrun=0, frame_count=0, byte counter=0.
- States: IDLE, XFER, DRAIN, IFG.
- IDLE: if any src_valid is high, grant the first requester searching from grant_id+1 modulo NUM_SRC. Update grant_id and go to XFER next cycle. src_ready stays 0 in IDLE. Output stays idle.
- XFER: src_ready[g]=1.
  - Each accepted byte appears on out_data with out_control=1 on the next cycle. The byte counter increments on each accept.
  - Accept with src_last: frame_count++ and go to IFG.
  - Accept without src_last with counter reaching MAX_BYTES: pulse oversize and go to DRAIN. No further bytes are forwarded.
  - src_valid[g]=0 while in XFER: that cycle is not an accept. Next cycle out_control=0 (frame broken toward epd). Pulse underrun and go to DRAIN.
- DRAIN: src_ready[g]=1, bytes are discarded, out_control=0. On accepted src_last go to IFG. frame_count is not incremented.
- IFG: out_control=0, out_data=0 for exactly IFG_MIN cycles, counted from the first idle output cycle after the frame's last forwarded byte. Then go to IDLE.
  - Minimum gap between frames on out_control is therefore IFG_MIN+1 (IFG cycles plus the IDLE grant cycle).
- Non-granted sources: src_ready=0. They may hold valid indefinitely. Their requests are only evaluated in IDLE; no preemption.
- Simultaneous src_last and MAX_BYTES reached on the same accept: treat as a normal completion (no oversize, count increments).
- Byte counter resets to 0 on entry to XFER. Width is ceil(log2(MAX_BYTES+1)).
- Reset asserted mid-frame: outputs go to reset values immediately. The partial frame is abandoned. The source must restart its frame after reset.

Test Plan:
- Single frame from src0 (7x8'h55, 8'hD5, DST 01..06, SRC FF..FA, 08 00, 49x8'h55, 8'hFF; 72 bytes) -> out_data identical, 1 cycle after each accept, out_control=1 for 72 cycles then 0 for 2; frame_count=1; epd valid_packet_counter=1.
- src0 and src1 both valid from reset release -> src0 frame forwarded first, then >=3 idle cycles, then src1 frame; grant_id 0 then 1; frame_count=2; epd counter=2.
- Three frames from src1 only while src0 is idle -> back-to-back grants to src1 each separated by 3 idle cycles; frame_count=3.
- src0 sends an 80-byte frame -> 72 bytes forwarded, oversize pulses once, 8 bytes drained with out_control=0, frame_count unchanged; next src1 frame forwarded normally.
- src0 drops src_valid after byte 20 for 1 cycle -> out_control=0 at byte 21 position, underrun pulses, remainder drained until src_last, frame_count unchanged.
- Reset low for 2 cycles during byte 30 of a src1 frame -> out_control=0, src_ready=0, frame_count=0 immediately; after release, src0 wins first grant when both request.
